// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo controller and datapath: ALU modes, FSM states
// and the bundle of control flags the controller presents to the datapath.
package modulo_pkg;

  localparam logic [2:0] ALU_NOP    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_CMP_LT = 3'd2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_INIT      = 4'd2,
    ST_CMP_ISSUE = 4'd3,
    ST_CMP_WAIT  = 4'd4,
    ST_CMP_WB    = 4'd5,
    ST_CHECK     = 4'd6,
    ST_SUB_ISSUE = 4'd7,
    ST_SUB_WAIT  = 4'd8,
    ST_SUB_WB    = 4'd9,
    ST_DONE      = 4'd10,
    ST_ERR       = 4'd11
  } state_e;

  typedef struct packed {
    logic [2:0] aluMode;
    logic       wrenUpdateZahlen;
    logic       wrenZahl1ToErg;
    logic       wrenTermErg;
    logic       wrenResToErg;
    logic       ergToAluA;
    logic       zahl2ToAluB;
    logic       checkForTermination;
    logic       busy;
    logic       done;
    logic       err;
  } ctrl_t;

  // Moore decode of a state into its flag bundle; at most one write enable per state.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c         = '0;
    c.aluMode = ALU_NOP;
    c.busy    = (s != ST_IDLE);
    case (s)
      ST_LOAD: c.wrenUpdateZahlen = 1'b1;
      ST_INIT: c.wrenZahl1ToErg   = 1'b1;
      ST_CMP_ISSUE, ST_CMP_WAIT: begin
        c.aluMode     = ALU_CMP_LT;
        c.ergToAluA   = 1'b1;
        c.zahl2ToAluB = 1'b1;
      end
      ST_CMP_WB: c.wrenTermErg = 1'b1;
      ST_CHECK:  c.checkForTermination = 1'b1;
      ST_SUB_ISSUE, ST_SUB_WAIT: begin
        c.aluMode     = ALU_SUB;
        c.ergToAluA   = 1'b1;
        c.zahl2ToAluB = 1'b1;
      end
      ST_SUB_WB: c.wrenResToErg = 1'b1;
      ST_DONE:   c.done = 1'b1;
      ST_ERR:    c.err  = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_modulo.sv
// Sequencer for the repeated-subtraction modulo datapath: load, compare, subtract,
// terminate on result < Zahl2 or abort after MAX_ITER subtractions.
module control_modulo
  import modulo_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 0,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       valid_i,
  output logic [2:0] alu_mode_o,
  output logic       wren_update_Zahlen_o,
  output logic       wren_Zahl1_to_erg_o,
  output logic       wren_term_erg_o,
  output logic       wren_res_to_erg_o,
  output logic       erg_to_alu_a_o,
  output logic       Zahl2_to_alu_b_o,
  output logic       check_for_termination_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned WAIT_W = $clog2(ALU_LAT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
  localparam logic [15:0] ITER_LIMIT = 16'(MAX_ITER);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [15:0]       iterCnt_q, iterCnt_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

  // Wait states stretch the ALU operand selection over ALU_LAT extra cycles.
  always_comb begin
    state_d   = state_q;
    iterCnt_d = iterCnt_q;
    waitCnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_LOAD;
          iterCnt_d = '0;
        end
      end
      ST_LOAD:      state_d = ST_INIT;
      ST_INIT:      state_d = ST_CMP_ISSUE;
      ST_CMP_ISSUE: state_d = (ALU_LAT == 0) ? ST_CMP_WB : ST_CMP_WAIT;
      ST_CMP_WAIT: begin
        if (waitCnt_q == WAIT_LAST) state_d = ST_CMP_WB;
        else                        waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
      ST_CMP_WB:    state_d = ST_CHECK;
      ST_CHECK: begin
        if (valid_i)                      state_d = ST_DONE;
        else if (iterCnt_q == ITER_LIMIT) state_d = ST_ERR;
        else                              state_d = ST_SUB_ISSUE;
      end
      ST_SUB_ISSUE: state_d = (ALU_LAT == 0) ? ST_SUB_WB : ST_SUB_WAIT;
      ST_SUB_WAIT: begin
        if (waitCnt_q == WAIT_LAST) state_d = ST_SUB_WB;
        else                        waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
      ST_SUB_WB: begin
        state_d   = ST_CMP_ISSUE;
        iterCnt_d = iterCnt_q + 16'd1;
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so every output is a clean Moore decode.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      iterCnt_q <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode_ctrl(state_d);
      iterCnt_q <= iterCnt_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign alu_mode_o              = ctrl_q.aluMode;
  assign wren_update_Zahlen_o    = ctrl_q.wrenUpdateZahlen;
  assign wren_Zahl1_to_erg_o     = ctrl_q.wrenZahl1ToErg;
  assign wren_term_erg_o         = ctrl_q.wrenTermErg;
  assign wren_res_to_erg_o       = ctrl_q.wrenResToErg;
  assign erg_to_alu_a_o          = ctrl_q.ergToAluA;
  assign Zahl2_to_alu_b_o        = ctrl_q.zahl2ToAluB;
  assign check_for_termination_o = ctrl_q.checkForTermination;
  assign busy_o                  = ctrl_q.busy;
  assign done_o                  = ctrl_q.done;
  assign err_o                   = ctrl_q.err;

endmodule

// File: tb/tb_control_modulo.sv
// Bench for control_modulo: two instances (ALU_LAT 0 / 2) each driving a behavioural
// datapath; runs are judged against arithmetic expectations for cycle counts and results.
module tb_control_modulo;

  localparam logic [2:0] MODE_SUB = 3'd1;
  localparam logic [2:0] MODE_CMP = 3'd2;

  logic        clk;
  logic        rst;
  logic        start [2];
  logic        valid [2];
  logic [2:0]  mode  [2];
  logic        wUpd [2], wInit [2], wTerm [2], wRes [2];
  logic        selA [2], selB [2], chk [2], busy [2], done [2], err [2];
  logic [15:0] z1 [2], z2 [2], za [2], zb [2], erg [2];
  logic        term [2];

  int total = 0;
  int bad   = 0;

  int endCyc, nUpd, nInit, nTerm, nRes, nChk, nCmp, nSub, nSel, nBusy, nViol;
  bit sawDone, sawErr;
  logic [15:0] ergEnd;
  logic [13:0] idleOuts;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    control_modulo #(
      .ALU_LAT  ((g == 0) ? 0 : 2),
      .MAX_ITER ((g == 0) ? 8 : 4)
    ) u_dut (
      .clk                     (clk),
      .rst_i                   (rst),
      .start_i                 (start[g]),
      .valid_i                 (valid[g]),
      .alu_mode_o              (mode[g]),
      .wren_update_Zahlen_o    (wUpd[g]),
      .wren_Zahl1_to_erg_o     (wInit[g]),
      .wren_term_erg_o         (wTerm[g]),
      .wren_res_to_erg_o       (wRes[g]),
      .erg_to_alu_a_o          (selA[g]),
      .Zahl2_to_alu_b_o        (selB[g]),
      .check_for_termination_o (chk[g]),
      .busy_o                  (busy[g]),
      .done_o                  (done[g]),
      .err_o                   (err[g])
    );
  end

  // Behavioural datapath: operand registers, running result and termination flag.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        za[d] <= '0; zb[d] <= '0; erg[d] <= '0; term[d] <= 1'b0;
      end else begin
        if (wUpd[d])  begin za[d] <= z1[d]; zb[d] <= z2[d]; term[d] <= 1'b0; end
        if (wInit[d]) erg[d]  <= za[d];
        if (wTerm[d]) term[d] <= (erg[d] < zb[d]);
        if (wRes[d])  erg[d]  <= erg[d] - zb[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) valid[d] = term[d] & chk[d];
  end

  function automatic int latOf(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int maxOf(int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic int subsOf(int d, int a, int b);
    if (b == 0 || a / b > maxOf(d)) return maxOf(d);
    return a / b;
  endfunction

  function automatic int cycOf(int d, int n);
    return 6 + latOf(d) + n * (5 + 2 * latOf(d));
  endfunction

  function automatic int limitOf(int d);
    return cycOf(d, maxOf(d) + 1) + 5;
  endfunction

  function automatic logic [13:0] outs(int d);
    return {mode[d], wUpd[d], wInit[d], wTerm[d], wRes[d], selA[d], selB[d],
            chk[d], busy[d], done[d], err[d]};
  endfunction

  // Launches one operation and records what the controller did, cycle by cycle.
  task automatic applyStimulus(input int d, input int a, input int b, input bit hold);
    endCyc = -1; sawDone = 0; sawErr = 0; ergEnd = '0; idleOuts = '1;
    nUpd = 0; nInit = 0; nTerm = 0; nRes = 0; nChk = 0;
    nCmp = 0; nSub = 0; nSel = 0; nBusy = 0; nViol = 0;
    @(negedge clk);
    z1[d] = 16'(a); z2[d] = 16'(b); start[d] = 1'b1;
    for (int c = 1; c <= limitOf(d); c++) begin
      @(negedge clk);
      if (!hold) start[d] = 1'b0;
      nUpd  += int'(wUpd[d]);  nInit += int'(wInit[d]);
      nTerm += int'(wTerm[d]); nRes  += int'(wRes[d]);
      nChk  += int'(chk[d]);   nBusy += int'(busy[d]);
      if (mode[d] == MODE_CMP && selA[d] && selB[d]) nCmp++;
      if (mode[d] == MODE_SUB && selA[d] && selB[d]) nSub++;
      if (mode[d] != 3'd0 || selA[d] || selB[d]) nSel++;
      if (int'(wUpd[d]) + int'(wInit[d]) + int'(wTerm[d]) + int'(wRes[d]) > 1) nViol++;
      if (done[d] || err[d]) begin
        endCyc = c; sawDone = done[d]; sawErr = err[d]; ergEnd = erg[d];
        break;
      end
    end
    if (endCyc > 0 && !hold) begin
      @(negedge clk);
      idleOuts = outs(d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; z1[d] = '0; z2[d] = '0; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (outs(d) !== 14'd0) begin
        bad++; $display("[TB] FAIL reset_outs dut%0d: got %h want 0", d, outs(d));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_after_reset: busy %b%b want 00", busy[0], busy[1]);
    end
  endtask

  task automatic test_no_sub();
    applyStimulus(0, 3, 7, 0);
    total++;
    if (!sawDone || endCyc != 6) begin
      bad++; $display("[TB] FAIL no_sub_done: cycle %0d done %0d want cycle 6", endCyc, sawDone);
    end
    total++;
    if (ergEnd !== 16'd3) begin
      bad++; $display("[TB] FAIL no_sub_result: got %0d want 3", ergEnd);
    end
    total++;
    if (nRes != 0 || nSub != 0) begin
      bad++; $display("[TB] FAIL no_sub_states: res %0d sub %0d want 0 0", nRes, nSub);
    end
  endtask

  task automatic test_multi_sub();
    applyStimulus(0, 17, 5, 0);
    total++;
    if (!sawDone || endCyc != 21) begin
      bad++; $display("[TB] FAIL multi_sub_done: cycle %0d want 21", endCyc);
    end
    total++;
    if (ergEnd !== 16'd2 || nRes != 3) begin
      bad++; $display("[TB] FAIL multi_sub_result: got %0d/%0d pulses want 2/3", ergEnd, nRes);
    end
    total++;
    if (idleOuts !== 14'd0) begin
      bad++; $display("[TB] FAIL multi_sub_idle: got %h want 0", idleOuts);
    end
  endtask

  task automatic test_alu_latency();
    applyStimulus(1, 17, 5, 0);
    total++;
    if (!sawDone || endCyc != 35) begin
      bad++; $display("[TB] FAIL latency_done: cycle %0d want 35", endCyc);
    end
    total++;
    if (ergEnd !== 16'd2) begin
      bad++; $display("[TB] FAIL latency_result: got %0d want 2", ergEnd);
    end
    total++;
    if (nCmp != 12 || nSub != 9 || nSel != 21) begin
      bad++; $display("[TB] FAIL latency_selects: cmp %0d sub %0d any %0d want 12 9 21", nCmp, nSub, nSel);
    end
  endtask

  task automatic test_zero_divisor();
    applyStimulus(1, 9, 0, 0);
    total++;
    if (!sawErr || sawDone || endCyc != cycOf(1, 4)) begin
      bad++; $display("[TB] FAIL zero_div_err: cycle %0d err %0d done %0d want cycle %0d err 1",
                      endCyc, sawErr, sawDone, cycOf(1, 4));
    end
    total++;
    if (nRes != 4) begin
      bad++; $display("[TB] FAIL zero_div_subs: got %0d want 4", nRes);
    end
    total++;
    if (idleOuts !== 14'd0) begin
      bad++; $display("[TB] FAIL zero_div_idle: got %h want 0", idleOuts);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int d, a, b, n;
      bit expDone;
      d = i % 2;
      b = int'($urandom_range(1, 40));
      a = int'($urandom_range(0, maxOf(d) + 2)) * b + int'($urandom_range(0, b - 1));
      n = subsOf(d, a, b);
      expDone = (a / b <= maxOf(d));
      applyStimulus(d, a, b, 0);
      total++;
      if (sawDone != expDone || sawErr == expDone || endCyc != cycOf(d, n)) begin
        bad++; $display("[TB] FAIL rand_end dut%0d %0d mod %0d: cycle %0d done %0d want cycle %0d done %0d",
                        d, a, b, endCyc, sawDone, cycOf(d, n), expDone);
      end
      total++;
      if (expDone && ergEnd !== 16'(a % b)) begin
        bad++; $display("[TB] FAIL rand_result %0d mod %0d: got %0d want %0d", a, b, ergEnd, a % b);
      end
      total++;
      if (nRes != n || nTerm != n + 1 || nChk != n + 1 || nUpd != 1 || nInit != 1) begin
        bad++; $display("[TB] FAIL rand_pulses %0d mod %0d: res %0d term %0d chk %0d upd %0d init %0d want n=%0d",
                        a, b, nRes, nTerm, nChk, nUpd, nInit, n);
      end
      total++;
      if (nCmp != (n + 1) * (1 + latOf(d)) || nSub != n * (1 + latOf(d)) || nSel != nCmp + nSub) begin
        bad++; $display("[TB] FAIL rand_alu %0d mod %0d: cmp %0d sub %0d any %0d", a, b, nCmp, nSub, nSel);
      end
      total++;
      if (nBusy != cycOf(d, n) || nViol != 0 || idleOuts !== 14'd0) begin
        bad++; $display("[TB] FAIL rand_busy %0d mod %0d: busy %0d viol %0d idle %h want busy %0d",
                        a, b, nBusy, nViol, idleOuts, cycOf(d, n));
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    z1[1] = 16'd20; z2[1] = 16'd3; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (mode[1] !== MODE_SUB || busy[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL pre_reset_sub: mode %0d busy %b want %0d 1", mode[1], busy[1], MODE_SUB);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs(1) !== 14'd0) begin
      bad++; $display("[TB] FAIL async_reset_outs: got %h want 0", outs(1));
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 10, 4, 0);
    total++;
    if (!sawDone || endCyc != 16 || ergEnd !== 16'd2) begin
      bad++; $display("[TB] FAIL post_reset_run: cycle %0d result %0d want 16 2", endCyc, ergEnd);
    end
  endtask

  task automatic checkOutput();
    int second;
    second = -1;
    total++;
    if (!sawDone || endCyc != 21 || nUpd != 1 || ergEnd !== 16'd2) begin
      bad++; $display("[TB] FAIL held_start_run: cycle %0d loads %0d result %0d want 21 1 2",
                      endCyc, nUpd, ergEnd);
    end
    @(negedge clk);
    total++;
    if (outs(0) !== 14'd0) begin
      bad++; $display("[TB] FAIL held_start_idle: got %h want 0", outs(0));
    end
    z1[0] = 16'd3; z2[0] = 16'd7;
    @(negedge clk);
    start[0] = 1'b0;
    total++;
    if (wUpd[0] !== 1'b1 || busy[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL back_to_back_load: upd %b busy %b want 1 1", wUpd[0], busy[0]);
    end
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (done[0]) begin second = c; break; end
    end
    total++;
    if (second != 6 || erg[0] !== 16'd3) begin
      bad++; $display("[TB] FAIL back_to_back_done: cycle %0d result %0d want 6 3", second, erg[0]);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 17, 5, 1);
    checkOutput();
  endtask

  initial begin
    test_reset();
    test_no_sub();
    test_multi_sub();
    test_alu_latency();
    test_zero_divisor();
    test_random();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
